// File: rtl/bd_handshake_rx.sv
// Purpose: receives 4-phase bundled-data words from the async core and presents them on a valid/ready port.
// Latency: i_req rise -> o_ack/o_valid at edge SYNC_STAGES+1; i_req fall -> o_ack fall at edge SYNC_STAGES+1.
// Backpressure: a full one-entry buffer holds off o_ack (WAIT_BUF) until the word drains.
module bd_handshake_rx #(
    parameter int DWIDTH      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_ack,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    input  logic              i_ready,
    output logic              o_proto_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUF = 2'd1,
        ACK_HI   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     ack_q, ack_d;
    logic                     valid_q, valid_d;
    logic [DWIDTH-1:0]        data_q, data_d;
    logic                     proto_err_q, proto_err_d;
    logic                     req_s;
    logic                     buf_free;
    logic                     load;

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign buf_free = !valid_q || i_ready;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], i_req};
        state_d     = state_q;
        ack_d       = ack_q;
        proto_err_d = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (buf_free) begin
                        load = 1'b1;
                    end else begin
                        state_d = WAIT_BUF;
                    end
                end
            end
            WAIT_BUF: begin
                // Sender gave up before we could acknowledge: drop the word, flag it.
                if (!req_s) begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (buf_free) begin
                    load = 1'b1;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase

        if (load) begin
            state_d = ACK_HI;
            ack_d   = 1'b1;
        end

        valid_d = load ? 1'b1 : (valid_q && !i_ready);
        data_d  = load ? i_data : data_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            ack_q       <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            ack_q       <= ack_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_proto_err = proto_err_q;

endmodule

// File: tb/tb_bd_handshake_rx.sv
// Directed bench for bd_handshake_rx: handshake latency, backpressure, streaming, reset, protocol error, bundling.
module tb_bd_handshake_rx;

    logic        i_clk;
    logic        i_rstn;
    logic        i_req;
    logic [31:0] i_data;
    logic        o_ack;
    logic        o_valid;
    logic [31:0] o_data;
    logic        i_ready;
    logic        o_proto_err;

    int checks;
    int failures;
    int err_pulses;
    logic [31:0] rx_q[$];

    bd_handshake_rx #(.DWIDTH(32), .SYNC_STAGES(2)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_proto_err(o_proto_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Transfers happen at the next posedge when valid&ready are both high mid-cycle.
    always @(negedge i_clk) begin
        if (i_rstn && o_valid && i_ready) rx_q.push_back(o_data);
        if (i_rstn && o_proto_err) err_pulses++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_ack(input logic val);
        for (int i = 0; i < 20 && o_ack !== val; i++) tick(1);
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({o_ack, o_valid, o_data, o_proto_err} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b valid=%b data=%h err=%b, need all zero",
                     o_ack, o_valid, o_data, o_proto_err);
        end
        tick(1);
        i_rstn = 1'b1;
        tick(2);
    endtask

    task automatic test_single;
        i_ready = 1'b1;
        i_data  = 32'hDEADBEEF;
        i_req   = 1'b1;
        tick(2);
        checks++;
        if (o_ack !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early: ack=%b valid=%b at edge 2, need 0 0", o_ack, o_valid);
        end
        tick(1);
        checks++;
        if (o_ack !== 1'b1 || o_valid !== 1'b1 || o_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_load: ack=%b valid=%b data=%h, need 1 1 deadbeef", o_ack, o_valid, o_data);
        end
        tick(1);
        checks++;
        if (o_valid !== 1'b0 || o_ack !== 1'b1) begin
            failures++;
            $display("FAIL single_drain: valid=%b ack=%b, need 0 1", o_valid, o_ack);
        end
        i_req = 1'b0;
        tick(2);
        checks++;
        if (o_ack !== 1'b1) begin
            failures++;
            $display("FAIL single_ack_hold: ack=%b at edge 2 after fall, need 1", o_ack);
        end
        tick(1);
        checks++;
        if (o_ack !== 1'b0) begin
            failures++;
            $display("FAIL single_ack_fall: ack=%b at edge 3 after fall, need 0", o_ack);
        end
    endtask

    task automatic test_backpressure;
        i_ready = 1'b0;
        i_data  = 32'h1;
        i_req   = 1'b1;
        tick(3);
        i_req = 1'b0;
        tick(3);
        i_data = 32'h2;
        i_req  = 1'b1;
        tick(5);
        checks++;
        if (o_ack !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'h1) begin
            failures++;
            $display("FAIL bp_wait: ack=%b valid=%b data=%h, need 0 1 00000001", o_ack, o_valid, o_data);
        end
        i_ready = 1'b1;
        tick(1);
        checks++;
        if (o_ack !== 1'b1 || o_valid !== 1'b1 || o_data !== 32'h2) begin
            failures++;
            $display("FAIL bp_drain_load: ack=%b valid=%b data=%h, need 1 1 00000002", o_ack, o_valid, o_data);
        end
        tick(1);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_final_drain: valid=%b, need 0", o_valid);
        end
        i_req = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        rx_q.delete();
        err_pulses = 0;
        i_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            i_data = 32'h10 + w;
            i_req  = 1'b1;
            wait_ack(1'b1);
            i_req = 1'b0;
            wait_ack(1'b0);
        end
        tick(2);
        checks++;
        if (rx_q.size() !== 4) begin
            failures++;
            $display("FAIL stream_count: got %0d transfers, need 4", rx_q.size());
        end
        for (int w = 0; w < 4 && w < rx_q.size(); w++) begin
            exp = 32'h10 + w;
            checks++;
            if (rx_q[w] !== exp) begin
                failures++;
                $display("FAIL stream_word%0d: got %h, need %h", w, rx_q[w], exp);
            end
        end
        checks++;
        if (err_pulses !== 0) begin
            failures++;
            $display("FAIL stream_proto_err: %0d pulses, need 0", err_pulses);
        end
    endtask

    task automatic test_reset_mid;
        i_ready = 1'b0;
        i_data  = 32'hAA;
        i_req   = 1'b1;
        tick(3);
        checks++;
        if (o_ack !== 1'b1 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: ack=%b valid=%b, need 1 1", o_ack, o_valid);
        end
        #2;
        i_rstn = 1'b0;
        #1;
        checks++;
        if (o_ack !== 1'b0 || o_valid !== 1'b0 || o_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_async: ack=%b valid=%b data=%h, need 0 0 0", o_ack, o_valid, o_data);
        end
        tick(1);
        i_rstn  = 1'b1;
        i_data  = 32'hBB;
        i_ready = 1'b1;
        tick(3);
        checks++;
        if (o_ack !== 1'b1 || o_valid !== 1'b1 || o_data !== 32'hBB) begin
            failures++;
            $display("FAIL rst_restart: ack=%b valid=%b data=%h, need 1 1 000000bb", o_ack, o_valid, o_data);
        end
        i_req = 1'b0;
        wait_ack(1'b0);
        tick(1);
    endtask

    task automatic test_proto_err;
        i_ready = 1'b0;
        i_data  = 32'h5;
        i_req   = 1'b1;
        wait_ack(1'b1);
        i_req = 1'b0;
        wait_ack(1'b0);
        err_pulses = 0;
        i_data = 32'h6;
        i_req  = 1'b1;
        tick(4);
        i_req = 1'b0;
        tick(3);
        checks++;
        if (o_proto_err !== 1'b1 || o_data !== 32'h5 || o_ack !== 1'b0) begin
            failures++;
            $display("FAIL perr_pulse: err=%b data=%h ack=%b, need 1 00000005 0", o_proto_err, o_data, o_ack);
        end
        tick(1);
        checks++;
        if (o_proto_err !== 1'b0) begin
            failures++;
            $display("FAIL perr_width: err=%b one cycle later, need 0", o_proto_err);
        end
        tick(3);
        checks++;
        if (err_pulses !== 1) begin
            failures++;
            $display("FAIL perr_count: %0d pulse cycles, need 1", err_pulses);
        end
        i_ready = 1'b1;
        tick(1);
        checks++;
        if (o_valid !== 1'b0 || o_ack !== 1'b0) begin
            failures++;
            $display("FAIL perr_idle: valid=%b ack=%b, need 0 0", o_valid, o_ack);
        end
        i_data = 32'h7;
        i_req  = 1'b1;
        tick(3);
        checks++;
        if (o_ack !== 1'b1 || o_data !== 32'h7) begin
            failures++;
            $display("FAIL perr_recover: ack=%b data=%h, need 1 00000007", o_ack, o_data);
        end
        i_req = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic test_bundling;
        i_ready = 1'b1;
        i_data  = 32'h11111111;
        tick(1);
        #2;
        i_data = 32'hCAFEF00D;
        #5;
        i_req = 1'b1;
        wait_ack(1'b1);
        checks++;
        if (o_ack !== 1'b1 || o_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL bundling: ack=%b data=%h, need 1 cafef00d", o_ack, o_data);
        end
        i_req = 1'b0;
        wait_ack(1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        err_pulses = 0;
        i_rstn  = 1'b0;
        i_req   = 1'b0;
        i_data  = 32'h0;
        i_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_proto_err();
        test_bundling();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
